cam_update_sequencer: RTL and testbench
=======================================

CAM_UPDATE_SEQUENCER -- requirements
Module: cam_update_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-003 cmd_op  in  2  00 reserved, 01 LOOKUP, 10 REPLACE, 11 INIT; cmd_key  in  4  search value; cmd_new  in  4  replacement value.
REQ-004 rsp_valid  out  1  response present; rsp_ready  in  1  response consumed when both high.
REQ-005 rsp_hit  out  1  key matched; rsp_min  out  3  lowest matching entry; rsp_max  out  3  highest matching entry; rsp_err  out  1  reserved op or verify failure.
REQ-006 CAM-side outputs, driving the 8x4 register block: D_lookup  out  4; setD  out  1; newD  out  4; init  out  1.
REQ-007 CAM-side inputs from the register block: valid  in  1; minAddr  in  3; maxAddr  in  3 (combinational match results for D_lookup).
REQ-008 op_count  out  8  count of setD pulses issued, saturating.

Function
REQ-009 FSM states SHALL be IDLE, LOOKUP, WRITE, VERIFY, INITS, RESP.
REQ-010 cmd_ready SHALL equal (state==IDLE); a command is captured (op, key, new) on the edge where cmd_valid&&cmd_ready.
REQ-011 Transitions from IDLE on accept: op 01/10 -> LOOKUP; op 11 -> INITS; op 00 -> RESP with rsp_err=1, rsp_hit=0.
REQ-012 LOOKUP (1 cycle): drive D_lookup=key; at the closing edge, register valid/minAddr/maxAddr into rsp_hit/rsp_min/rsp_max.
REQ-013 From LOOKUP: op LOOKUP -> RESP; op REPLACE with valid=1 -> WRITE; op REPLACE with valid=0 -> RESP (no setD).
REQ-014 WRITE (exactly 1 cycle): setD=1, D_lookup=key, newD=new; increment op_count, saturating at 255; -> VERIFY.
REQ-015 VERIFY (1 cycle): D_lookup=key; rsp_err=1 if (key!=new && valid==1) or (key==new && valid==0), else 0; rsp_min/rsp_max keep the LOOKUP values; -> RESP.
REQ-016 INITS (exactly 1 cycle): init=1; rsp_hit=0, rsp_min=0, rsp_max=0, rsp_err=0; -> RESP.
REQ-017 RESP: rsp_valid=1; all rsp_* SHALL hold stable until rsp_valid&&rsp_ready, then -> IDLE.
REQ-018 Latency from the accept edge N: LOOKUP and REPLACE-miss rsp_valid at N+2; REPLACE-hit at N+4; INIT at N+2; reserved op at N+1.
REQ-019 setD and init SHALL never be high outside WRITE and INITS respectively, and never together.
REQ-020 D_lookup and newD SHALL be 0 in IDLE and RESP.
REQ-021 Back-to-back operation: rsp_ready high in RESP SHALL allow a new accept on the very next cycle (IDLE), with no extra bubble.
REQ-022 rsp_err SHALL be cleared at every accept.

Reset
REQ-023 While reset is high at an edge: state -> IDLE, op_count=0, rsp_valid=0, rsp_hit=0, rsp_min=0, rsp_max=0, rsp_err=0, setD=0, init=0, D_lookup=0, newD=0.
REQ-024 Reset SHALL override any state, including mid-WRITE: setD is low in the cycle after the reset edge and the pending response is discarded.
REQ-025 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-026 INIT, then LOOKUP key=C -> rsp_hit=1, rsp_min=4, rsp_max=4, rsp_err=0 at N+2; LOOKUP key=8 -> rsp_min=0, rsp_max=0.
REQ-027 After INIT, REPLACE key=C new=8 -> setD pulsed exactly 1 cycle, rsp_hit=1, rsp_min=4, rsp_max=4, rsp_err=0 at N+4, op_count=1; then LOOKUP key=8 -> rsp_min=0, rsp_max=4.
REQ-028 REPLACE key=3 (absent) -> no setD, rsp_hit=0, rsp_valid at N+2, op_count unchanged; op 00 -> rsp_err=1 at N+1.
REQ-029 Hold rsp_ready=0 for 3 cycles in RESP -> rsp_* stable, cmd_ready=0, a cmd_valid held high throughout is not accepted until after the response handshake.
REQ-030 Assert reset during WRITE -> setD=0 next cycle, op_count=0, rsp_valid=0, cmd_ready=1 after release; REPLACE key=9 new=9 -> rsp_err=0, op_count=1.

Source files
------------

// File: rtl/cam_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cam_update_sequencer
//  Description : Sequences LOOKUP / REPLACE / INIT commands against an external
//                8x4 CAM register block and returns a single response per
//                command (hit, lowest/highest matching entry, error flag).
//                REPLACE runs lookup, a one-cycle write and a verify lookup
//                that checks the write took effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_update_sequencer (
    input  logic       clk,
    input  logic       reset,
    // command channel
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_key,
    input  logic [3:0] cmd_new,
    // response channel
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_hit,
    output logic [2:0] rsp_min,
    output logic [2:0] rsp_max,
    output logic       rsp_err,
    // CAM register block control
    output logic [3:0] D_lookup,
    output logic       setD,
    output logic [3:0] newD,
    output logic       init,
    // CAM register block match results for D_lookup
    input  logic       valid,
    input  logic [2:0] minAddr,
    input  logic [2:0] maxAddr,
    // number of write pulses issued, saturating
    output logic [7:0] op_count
);

    // command opcodes
    localparam logic [1:0] c_OP_RSVD    = 2'b00;
    localparam logic [1:0] c_OP_LOOKUP  = 2'b01;
    localparam logic [1:0] c_OP_REPLACE = 2'b10;
    localparam logic [1:0] c_OP_INIT    = 2'b11;

    // sequencer states
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOOKUP = 3'd1;
    localparam logic [2:0] c_WRITE  = 3'd2;
    localparam logic [2:0] c_VERIFY = 3'd3;
    localparam logic [2:0] c_INITS  = 3'd4;
    localparam logic [2:0] c_RESP   = 3'd5;

    logic [2:0] r_state;
    logic [1:0] r_op;
    logic [3:0] r_key;
    logic [3:0] r_new;

    logic       w_accept;
    logic       w_verify_err;
    logic [7:0] w_op_count_next;

    assign cmd_ready = (r_state == c_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // After the write, an unchanged key must still match and a changed key
    // must no longer match anywhere.
    assign w_verify_err = (r_key != r_new) ? valid : ~valid;

    assign w_op_count_next = (op_count == 8'hFF) ? op_count : op_count + 8'd1;

    // Sequencer: state, captured command, CAM drive and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_op      <= c_OP_RSVD;
            r_key     <= 4'd0;
            r_new     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_min   <= 3'd0;
            rsp_max   <= 3'd0;
            rsp_err   <= 1'b0;
            D_lookup  <= 4'd0;
            setD      <= 1'b0;
            newD      <= 4'd0;
            init      <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            // strobes are single-cycle unless a state below re-asserts them
            setD <= 1'b0;
            init <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    D_lookup <= 4'd0;
                    newD     <= 4'd0;
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_key   <= cmd_key;
                        r_new   <= cmd_new;
                        rsp_err <= 1'b0;
                        case (cmd_op)
                            c_OP_LOOKUP, c_OP_REPLACE: begin
                                r_state  <= c_LOOKUP;
                                D_lookup <= cmd_key;
                            end
                            c_OP_INIT: begin
                                r_state <= c_INITS;
                                init    <= 1'b1;
                            end
                            default: begin
                                // reserved op answers immediately with an error
                                r_state   <= c_RESP;
                                rsp_valid <= 1'b1;
                                rsp_hit   <= 1'b0;
                                rsp_min   <= 3'd0;
                                rsp_max   <= 3'd0;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end

                c_LOOKUP: begin
                    rsp_hit <= valid;
                    rsp_min <= minAddr;
                    rsp_max <= maxAddr;
                    if ((r_op == c_OP_REPLACE) && valid) begin
                        // D_lookup keeps the key so the CAM knows what to replace
                        r_state  <= c_WRITE;
                        setD     <= 1'b1;
                        newD     <= r_new;
                        op_count <= w_op_count_next;
                    end else begin
                        r_state   <= c_RESP;
                        rsp_valid <= 1'b1;
                        D_lookup  <= 4'd0;
                    end
                end

                c_WRITE: begin
                    r_state <= c_VERIFY;
                    newD    <= 4'd0;
                end

                c_VERIFY: begin
                    // hit/min/max keep the values from the first lookup
                    rsp_err   <= w_verify_err;
                    r_state   <= c_RESP;
                    rsp_valid <= 1'b1;
                    D_lookup  <= 4'd0;
                end

                c_INITS: begin
                    rsp_hit   <= 1'b0;
                    rsp_min   <= 3'd0;
                    rsp_max   <= 3'd0;
                    rsp_err   <= 1'b0;
                    r_state   <= c_RESP;
                    rsp_valid <= 1'b1;
                end

                c_RESP: begin
                    D_lookup <= 4'd0;
                    newD     <= 4'd0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end

                default: begin
                    r_state   <= c_IDLE;
                    rsp_valid <= 1'b0;
                    D_lookup  <= 4'd0;
                    newD      <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_update_sequencer
//  Description : Directed self-checking bench for cam_update_sequencer with a
//                behavioural 8x4 CAM register block (INIT loads entry i with
//                8+i; setD rewrites every entry equal to D_lookup with newD).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_update_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_key;
    logic [3:0] cmd_new;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [2:0] rsp_min;
    logic [2:0] rsp_max;
    logic       rsp_err;
    logic [3:0] D_lookup;
    logic       setD;
    logic [3:0] newD;
    logic       init;
    logic       cam_valid;
    logic [2:0] cam_min;
    logic [2:0] cam_max;
    logic [7:0] op_count;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_overlap = 0;

    logic [3:0] cam [8];

    cam_update_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_key   (cmd_key),
        .cmd_new   (cmd_new),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_min   (rsp_min),
        .rsp_max   (rsp_max),
        .rsp_err   (rsp_err),
        .D_lookup  (D_lookup),
        .setD      (setD),
        .newD      (newD),
        .init      (init),
        .valid     (cam_valid),
        .minAddr   (cam_min),
        .maxAddr   (cam_max),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // CAM storage: init loads a fixed pattern, setD replaces matching entries
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 8; i++) cam[i] <= 4'(8 + i);
        end else if (setD) begin
            for (int i = 0; i < 8; i++) if (cam[i] == D_lookup) cam[i] <= newD;
        end
    end

    // CAM match: scan downward so the first hit is the highest entry
    always_comb begin
        cam_valid = 1'b0;
        cam_min   = 3'd0;
        cam_max   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cam[i] == D_lookup) begin
                if (!cam_valid) cam_max = 3'(i);
                cam_valid = 1'b1;
                cam_min   = 3'(i);
            end
        end
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer a command and let it be accepted; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] key, input logic [3:0] nw);
        int waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_new   = nw;
        while (!cmd_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("issue/cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Wait for the response after an accept, check it, then consume it.
    // Latency k means rsp_valid is high just before the k-th edge after accept.
    task automatic collect(input string tag, input int exp_lat, input int exp_hit,
                           input int exp_min, input int exp_max, input int exp_err,
                           input int exp_setd, input int exp_init);
        int lat   = 0;
        int nsetd = 0;
        int ninit = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (setD) nsetd++;
            if (init) ninit++;
            if (setD && init) n_overlap++;
            if (rsp_valid) lat = k;
        end
        check({tag, "/latency"}, 32'(lat), exp_lat);
        check({tag, "/hit"},     32'(rsp_hit), exp_hit);
        check({tag, "/min"},     32'(rsp_min), exp_min);
        check({tag, "/max"},     32'(rsp_max), exp_max);
        check({tag, "/err"},     32'(rsp_err), exp_err);
        check({tag, "/setD_cycles"}, 32'(nsetd), exp_setd);
        check({tag, "/init_cycles"}, 32'(ninit), exp_init);
        check({tag, "/D_lookup_resp"}, 32'(D_lookup), 0);
        check({tag, "/newD_resp"},     32'(newD), 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_key   = 4'h0;
        cmd_new   = 4'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/rsp_valid", 32'(rsp_valid), 0);
        check("reset/op_count",  32'(op_count), 0);
        check("reset/setD",      32'(setD), 0);
        check("reset/init",      32'(init), 0);
        check("reset/D_lookup",  32'(D_lookup), 0);
        check("reset/newD",      32'(newD), 0);
        check("reset/rsp_err",   32'(rsp_err), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset/cmd_ready_after", 32'(cmd_ready), 1);

        // INIT: CAM = 8 9 A B C D E F
        issue(2'b11, 4'h0, 4'h0);
        collect("init", 2, 0, 0, 0, 0, 0, 1);
        issue(2'b01, 4'hC, 4'h0);
        collect("lookup_C", 2, 1, 4, 4, 0, 0, 0);
        issue(2'b01, 4'h8, 4'h0);
        collect("lookup_8", 2, 1, 0, 0, 0, 0, 0);

        // REPLACE C->8: CAM = 8 9 A B 8 D E F
        issue(2'b10, 4'hC, 4'h8);
        collect("replace_C8", 4, 1, 4, 4, 0, 1, 0);
        check("replace_C8/op_count", 32'(op_count), 1);
        issue(2'b01, 4'h8, 4'h0);
        collect("lookup_8b", 2, 1, 0, 4, 0, 0, 0);

        // REPLACE of an absent key, then a reserved op
        issue(2'b10, 4'h3, 4'h5);
        collect("replace_miss", 2, 0, 0, 0, 0, 0, 0);
        check("replace_miss/op_count", 32'(op_count), 1);
        issue(2'b00, 4'h1, 4'h2);
        collect("reserved", 1, 0, 0, 0, 1, 0, 0);

        // Backpressure: response held 3 extra cycles, next command waiting
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_key   = 4'h9;
        cmd_new   = 4'h0;
        check("bp/ready_idle", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_key = 4'hA;
        @(negedge clk);
        check("bp/ready_busy", 32'(cmd_ready), 0);
        @(negedge clk);
        check("bp/rsp_valid", 32'(rsp_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp/hold_valid", 32'(rsp_valid), 1);
            check("bp/hold_hit",   32'(rsp_hit), 1);
            check("bp/hold_min",   32'(rsp_min), 1);
            check("bp/hold_max",   32'(rsp_max), 1);
            check("bp/hold_err",   32'(rsp_err), 0);
            check("bp/hold_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp/no_bubble", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        collect("bp/lookup_A", 2, 1, 2, 2, 0, 0, 0);

        // Reset during WRITE (REPLACE D->E)
        issue(2'b10, 4'hD, 4'hE);
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (setD) seen = 1;
        end
        check("rst_write/setD_seen", 32'(seen), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_write/setD",      32'(setD), 0);
        check("rst_write/op_count",  32'(op_count), 0);
        check("rst_write/rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_write/cmd_ready", 32'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        check("rst_write/no_rsp",    32'(rsp_valid), 0);

        // REPLACE 9->9 after reset: write happens, verify still matches
        issue(2'b10, 4'h9, 4'h9);
        collect("replace_99", 4, 1, 1, 1, 0, 1, 0);
        check("replace_99/op_count", 32'(op_count), 1);

        check("strobe_overlap", 32'(n_overlap), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
